// File: rtl/m_frame_scheduler.sv
// Frame scheduler for a tile/sprite video pipeline.
// Steps the background fill, game logic and sprite renderer units once per
// frame tick. Each unit gets a watchdog so a unit that never reports done
// cannot hang the pipeline. Sticky flags record overrun and timeout events.
module m_frame_scheduler #(
  parameter int TICK_DIV = 833333,
  parameter int TIMEOUT  = 65535
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        pause,
  input  logic        clr_err,
  input  logic        bg_done,
  input  logic        logic_done,
  input  logic        rend_done,
  output logic        bg_en,
  output logic        logic_en,
  output logic        rend_en,
  output logic        frame_tick,
  output logic [15:0] frame_count,
  output logic        overrun,
  output logic        timeout_err,
  output logic        busy,
  output logic [2:0]  state
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  // Watchdog holds 0 in the first cycle of a unit, so the last allowed
  // cycle sees TIMEOUT-1.
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BG_FILL   = 3'd1,
    S_WAIT_TICK = 3'd2,
    S_LOGIC     = 3'd3,
    S_RENDER    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                pending_q, pending_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;

  logic                unit_active;
  logic                wd_expire;
  logic                frame_inc;
  logic                timeout_set;
  logic                overrun_set;

  // Outputs decode straight from registers so reset drops them at once.
  assign frame_tick  = (tick_cnt_q == TICK_LAST);
  assign unit_active = (state_q == S_BG_FILL) || (state_q == S_LOGIC) ||
                       (state_q == S_RENDER);
  assign wd_expire   = (wdog_q == WD_LAST);

  assign bg_en       = (state_q == S_BG_FILL);
  assign logic_en    = (state_q == S_LOGIC);
  assign rend_en     = (state_q == S_RENDER);
  assign busy        = unit_active;
  assign state       = state_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

  // Free-running tick divider, independent of the sequencer state.
  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Next-state logic: a unit's done only matters in that unit's own state,
  // and a done in the expiry cycle wins over the watchdog.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    frame_inc   = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_BG_FILL;
      end
      S_BG_FILL: begin
        if (bg_done) begin
          state_d = S_WAIT_TICK;
        end else if (wd_expire) begin
          state_d     = S_WAIT_TICK;
          timeout_set = 1'b1;
        end
      end
      S_WAIT_TICK: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (pause) begin
          state_d = S_WAIT_TICK;
        end else if (frame_tick || pending_q) begin
          state_d = S_LOGIC;
        end
      end
      S_LOGIC: begin
        if (logic_done) begin
          state_d = S_RENDER;
        end else if (wd_expire) begin
          state_d     = S_WAIT_TICK;
          timeout_set = 1'b1;
        end
      end
      S_RENDER: begin
        if (rend_done) begin
          state_d   = S_WAIT_TICK;
          frame_inc = 1'b1;
        end else if (wd_expire) begin
          state_d     = S_WAIT_TICK;
          timeout_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending tick, watchdog, frame counter and sticky error flags.
  always_comb begin
    pending_d   = pending_q;
    overrun_set = 1'b0;
    // Ticks landing while a unit runs are remembered once; a second one is
    // an overrun. Ticks in WAIT_TICK are either consumed or discarded.
    if (unit_active && frame_tick) begin
      overrun_set = pending_q;
      pending_d   = 1'b1;
    end
    if ((state_d != state_q) && ((state_d == S_LOGIC) || (state_d == S_IDLE))) begin
      pending_d = 1'b0;
    end

    if (state_d != state_q) begin
      wdog_d = '0;
    end else if (unit_active) begin
      wdog_d = wdog_q + WD_W'(1);
    end else begin
      wdog_d = '0;
    end

    frame_count_d = frame_count_q + {15'd0, frame_inc};

    // A set event in the same cycle beats clr_err.
    overrun_d = overrun_set ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
    timeout_d = timeout_set ? 1'b1 : (clr_err ? 1'b0 : timeout_q);
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      tick_cnt_q    <= '0;
      wdog_q        <= '0;
      pending_q     <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // values from before this edge, independent of statement order.
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      wdog_q        <= wdog_d;
      pending_q     <= pending_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_m_frame_scheduler.sv
// Self-checking bench for m_frame_scheduler (TICK_DIV=10, TIMEOUT=20).
// A cycle-level behavioural model is compared against the DUT on every
// negative edge; directed scenarios add hand-computed expectations.
module tb_m_frame_scheduler;

  localparam int TICK_DIV = 10;
  localparam int TIMEOUT  = 20;

  localparam int P_IDLE   = 0;
  localparam int P_BG     = 1;
  localparam int P_WAIT   = 2;
  localparam int P_LOGIC  = 3;
  localparam int P_RENDER = 4;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start, pause, clr_err;
  logic        bg_done, logic_done, rend_done;
  logic        bg_en, logic_en, rend_en;
  logic        frame_tick;
  logic [15:0] frame_count;
  logic        overrun, timeout_err, busy;
  logic [2:0]  state;

  m_frame_scheduler #(.TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .pause       (pause),
    .clr_err     (clr_err),
    .bg_done     (bg_done),
    .logic_done  (logic_done),
    .rend_done   (rend_done),
    .bg_en       (bg_en),
    .logic_en    (logic_en),
    .rend_en     (rend_en),
    .frame_tick  (frame_tick),
    .frame_count (frame_count),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .busy        (busy),
    .state       (state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic en_of(input int u);
    case (u)
      0:       return bg_en;
      1:       return logic_en;
      default: return rend_en;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  int m_phase, m_cyc, m_dwell, m_frames;
  bit m_pend, m_ovr, m_tmo;

  initial begin
    logic [31:0] act, exp;
    bit tick, ovr_set, tmo_set, done_here, in_unit;
    int nxt;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        m_phase = P_IDLE; m_cyc = 0; m_dwell = 0; m_frames = 0;
        m_pend = 0; m_ovr = 0; m_tmo = 0;
      end else begin
        tick    = (m_cyc % TICK_DIV) == (TICK_DIV - 1);
        in_unit = (m_phase == P_BG) || (m_phase == P_LOGIC) || (m_phase == P_RENDER);
        exp = 32'({m_phase[2:0], m_frames[15:0], m_phase == P_BG, m_phase == P_LOGIC,
                   m_phase == P_RENDER, tick, m_ovr, m_tmo, in_unit});
        act = 32'({state, frame_count, bg_en, logic_en, rend_en, frame_tick,
                   overrun, timeout_err, busy});
        check("cycle outputs {state,count,bg,logic,rend,tick,ovr,tmo,busy}", act, exp);

        nxt = m_phase; ovr_set = 0; tmo_set = 0;
        if (in_unit) begin
          if (tick) begin
            if (m_pend) ovr_set = 1;
            m_pend = 1;
          end
          done_here = (m_phase == P_BG && bg_done) || (m_phase == P_LOGIC && logic_done) ||
                      (m_phase == P_RENDER && rend_done);
          if (done_here) begin
            nxt = (m_phase == P_LOGIC) ? P_RENDER : P_WAIT;
            if (m_phase == P_RENDER) m_frames = (m_frames + 1) % 65536;
          end else if (m_dwell + 1 == TIMEOUT) begin
            nxt = P_WAIT;
            tmo_set = 1;
          end
        end else if (m_phase == P_IDLE) begin
          if (start) nxt = P_BG;
        end else begin
          if (!start) begin
            nxt = P_IDLE; m_pend = 0;
          end else if (!pause && (tick || m_pend)) begin
            nxt = P_LOGIC; m_pend = 0;
          end
        end
        m_dwell = (nxt == m_phase) ? m_dwell + 1 : 0;
        m_ovr   = ovr_set | (m_ovr & ~clr_err);
        m_tmo   = tmo_set | (m_tmo & ~clr_err);
        m_phase = nxt;
        m_cyc++;
      end
    end
  end

  // ---------------- unit responders ----------------
  // Each unit pulses done when its enable has been high for dly[u]+1 cycles;
  // dly[u] = -1 means the unit never answers.
  int dly[3];
  int cnt[3];
  bit was[3];

  initial begin
    forever begin
      @(posedge clock);
      #1;
      for (int u = 0; u < 3; u++) begin
        if (en_of(u)) cnt[u] = was[u] ? cnt[u] + 1 : 0;
        was[u] = en_of(u);
      end
      bg_done    = bg_en    && (cnt[0] == dly[0]);
      logic_done = logic_en && (cnt[1] == dly[1]);
      rend_done  = rend_en  && (cnt[2] == dly[2]);
    end
  end

  // Waits (bounded) for unit u's enable to rise, then counts its high cycles.
  // tick_before is frame_tick in the cycle before the rise; waited is the
  // number of cycles spent waiting.
  task automatic measure(input int u, output int hi, output bit tick_before, output int waited);
    bit prev;
    hi = 0; tick_before = 0; waited = 0; prev = frame_tick;
    while (!en_of(u) && waited < 300) begin
      prev = frame_tick;
      @(negedge clock);
      waited++;
    end
    if (!en_of(u)) begin
      check($sformatf("unit%0d enable rise", u), 32'(en_of(u)), 32'd1);
      return;
    end
    tick_before = prev;
    while (en_of(u) && hi < 300) begin
      hi++;
      @(negedge clock);
    end
  endtask

  task automatic pulse_clr();
    @(posedge clock); #1 clr_err = 1'b1;
    @(posedge clock); #1 clr_err = 1'b0;
    @(negedge clock);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int hi, waited, lo_cnt;
    bit tb;
    resetn = 1'b0; start = 1'b0; pause = 1'b0; clr_err = 1'b0;
    bg_done = 1'b0; logic_done = 1'b0; rend_done = 1'b0;
    dly = '{3, 3, 3};
    cnt = '{0, 0, 0};
    was = '{0, 0, 0};

    repeat (3) @(negedge clock);
    check("reset outputs", 32'({state, frame_count, bg_en, logic_en, rend_en, frame_tick,
                                overrun, timeout_err, busy}), 32'd0);

    // Normal frame.
    @(posedge clock); #1 resetn = 1'b1; start = 1'b1;
    measure(0, hi, tb, waited); check("bg_en width", 32'(hi), 32'd4);
    measure(1, hi, tb, waited); check("logic_en width", 32'(hi), 32'd4);
    check("logic_en follows tick", 32'(tb), 32'd1);
    measure(2, hi, tb, waited); check("rend_en width", 32'(hi), 32'd4);
    check("frame_count after frame 1", 32'(frame_count), 32'd1);

    // Overrun: logic held for 16 cycles, two ticks land before WAIT_TICK.
    dly[1] = 15;
    measure(1, hi, tb, waited); check("slow logic_en width", 32'(hi), 32'd16);
    dly[1] = 3;
    measure(2, hi, tb, waited); check("rend_en width frame 2", 32'(hi), 32'd4);
    check("overrun set", 32'(overrun), 32'd1);
    check("frame_count after frame 2", 32'(frame_count), 32'd2);
    measure(1, hi, tb, waited);
    check("pending logic entry without tick", 32'(tb), 32'd0);
    check("pending logic entry delay", 32'(waited), 32'd1);
    check("logic_en width frame 3", 32'(hi), 32'd4);
    measure(2, hi, tb, waited); check("rend_en width frame 3", 32'(hi), 32'd4);
    check("frame_count after frame 3", 32'(frame_count), 32'd3);
    dly[2] = -1;
    pulse_clr();
    check("overrun cleared", 32'(overrun), 32'd0);

    // Timeout: renderer never answers.
    measure(2, hi, tb, waited); check("rend_en timeout width", 32'(hi), 32'd20);
    dly[2] = 3;
    check("timeout_err set", 32'(timeout_err), 32'd1);
    check("frame_count unchanged by timeout", 32'(frame_count), 32'd3);
    pulse_clr();
    check("timeout_err cleared", 32'(timeout_err), 32'd0);

    // Pause across three ticks, released mid-period.
    @(posedge clock); #1 resetn = 1'b0; pause = 1'b1;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    measure(0, hi, tb, waited); check("bg_en width after reset", 32'(hi), 32'd4);
    lo_cnt = 0;
    repeat (30) begin
      @(negedge clock);
      if (logic_en) lo_cnt++;
    end
    check("logic_en held off by pause", 32'(lo_cnt), 32'd0);
    @(posedge clock); #1 pause = 1'b0;
    dly[2] = 19;
    measure(1, hi, tb, waited);
    check("logic_en waits for tick after pause", 32'(tb), 32'd1);
    check("logic_en not immediate after pause", 32'(waited > 1), 32'd1);

    // Boundary: renderer answers in its 20th cycle.
    measure(2, hi, tb, waited); check("rend_en boundary width", 32'(hi), 32'd20);
    check("frame_count after boundary done", 32'(frame_count), 32'd1);
    check("timeout_err clear at boundary", 32'(timeout_err), 32'd0);
    dly[2] = -1;

    // Asynchronous reset during RENDER.
    waited = 0;
    while (!rend_en && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    check("rend_en reached before reset", 32'(rend_en), 32'd1);
    @(posedge clock); #3 resetn = 1'b0; start = 1'b0;
    #1;
    check("async reset outputs", 32'({state, bg_en, logic_en, rend_en, busy, frame_count}), 32'd0);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    repeat (5) @(negedge clock);
    check("idle after reset release", 32'({state, bg_en}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

endmodule
